// File: rtl/zx_key_decoder_if.sv
// Code output channel of zx_key_decoder: 16-bit key code with valid/ready handshake.
interface zx_key_decoder_if;
  logic [15:0] code_out;
  logic        code_valid;
  logic        code_ready;

  modport master (output code_out, output code_valid, input code_ready);
  modport slave  (input code_out, input code_valid, output code_ready);
endinterface

// File: rtl/zx_key_decoder.sv
// ZX Spectrum keyboard-matrix decoder: debounced key codes queued in a small FIFO.
// Optional release codes (bit 7 set) are enabled by defining ZX_KEYDEC_RELEASE_EN.
module zx_key_decoder #(
  parameter int unsigned DEBOUNCE_TICKS = 270000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4:0]              key_0,
  input  logic [4:0]              key_1,
  input  logic [4:0]              key_2,
  input  logic [4:0]              key_3,
  input  logic [4:0]              key_4,
  input  logic [4:0]              key_5,
  input  logic [4:0]              key_6,
  input  logic [4:0]              key_7,
  zx_key_decoder_if.master        code_if,
  output logic                    key_down,
  output logic                    overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] DB = 32'(DEBOUNCE_TICKS);
  // CS is key_0[0] (bit 0), SS is key_7[1] (bit 36)
  localparam logic [39:0] MOD_MASK = 40'h10_0000_0001;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PRESS_DB = 3'd1;
  localparam logic [2:0] S_EMIT     = 3'd2;
  localparam logic [2:0] S_HELD     = 3'd3;
  localparam logic [2:0] S_REL_DB   = 3'd4;
`ifdef ZX_KEYDEC_RELEASE_EN
  localparam logic [2:0] S_EMIT_REL = 3'd5;
`endif

  logic [39:0] m_q, m_d;
  logic [39:0] snap_q, snap_d;
  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        overflow_q, overflow_d;

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;

  logic [39:0] m_nm;
  logic [39:0] snap_nm;
  logic        nm_any;
  logic [31:0] cnt_inc;
  logic [2:0]  row_idx;
  logic [4:0]  row_bits;
  logic        row_found;
  logic [15:0] press_code;
  logic [15:0] push_code;
  logic        push;
  logic        pop;
  logic        full;
  logic        wr_en;

  assign m_d     = {key_7, key_6, key_5, key_4, key_3, key_2, key_1, key_0};
  assign m_nm    = m_q | MOD_MASK;
  assign snap_nm = snap_q | MOD_MASK;
  assign nm_any  = ~&m_nm;
  assign cnt_inc = (cnt_q >= DB) ? DB : cnt_q + 32'd1;

  // Lowest-numbered row with a non-modifier key down wins; no rollover.
  always_comb begin
    row_idx   = '0;
    row_bits  = '1;
    row_found = 1'b0;
    for (int unsigned r = 0; r < 8; r++) begin
      if (!row_found && !(&snap_nm[5*r +: 5])) begin
        row_idx   = 3'(r);
        row_bits  = snap_nm[5*r +: 5];
        row_found = 1'b1;
      end
    end
    press_code = {5'b0, row_idx, 1'b0, ~snap_q[0], ~snap_q[36], row_bits};
  end

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_code = press_code;
    case (state_q)
      S_IDLE: begin
        if (nm_any) begin
          snap_d  = m_q;
          cnt_d   = '0;
          state_d = S_PRESS_DB;
        end
      end
      S_PRESS_DB: begin
        if (m_q == snap_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB) state_d = S_EMIT;
        end else if (!nm_any) begin
          state_d = S_IDLE;
        end else begin
          snap_d = m_q;
          cnt_d  = '0;
        end
      end
      S_EMIT: begin
        push    = 1'b1;
        state_d = S_HELD;
      end
      S_HELD: begin
        if (!nm_any) begin
          cnt_d   = '0;
          state_d = S_REL_DB;
        end
      end
      S_REL_DB: begin
        if (nm_any) begin
          state_d = S_HELD;
        end else begin
          cnt_d = cnt_inc;
`ifdef ZX_KEYDEC_RELEASE_EN
          if (cnt_inc == DB) state_d = S_EMIT_REL;
`else
          if (cnt_inc == DB) state_d = S_IDLE;
`endif
        end
      end
`ifdef ZX_KEYDEC_RELEASE_EN
      // Snapshot is untouched since EMIT, so the press code is rebuilt with the same modifiers.
      S_EMIT_REL: begin
        push      = 1'b1;
        push_code = press_code | 16'h0080;
        state_d   = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign full  = (fill_q == (AW+1)'(FIFO_DEPTH));
  assign pop   = (fill_q != '0) && code_if.code_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign wr_en = push && (!full || pop);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    overflow_d = overflow_q | (push && full && !pop);
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_code;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q        <= '1;
      snap_q     <= '1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
    end else begin
      m_q        <= m_d;
      snap_q     <= snap_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
    end
  end

  assign code_if.code_valid = (fill_q != '0);
  assign code_if.code_out   = (fill_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign overflow           = overflow_q;
`ifdef ZX_KEYDEC_RELEASE_EN
  assign key_down = (state_q == S_HELD) || (state_q == S_REL_DB) || (state_q == S_EMIT_REL);
`else
  assign key_down = (state_q == S_HELD) || (state_q == S_REL_DB);
`endif

endmodule

// File: doc/zx_key_decoder.md
# zx_key_decoder

Keyboard-matrix decoder for the ZX Spectrum core. It watches the eight active-low 5-bit half-row vectors `key_0`..`key_7` on the keyboard side of the ULA and turns stable key presses into 16-bit key codes. Codes use the same format the key-sequence player consumes, so a decoded stream can be replayed unchanged. Codes are debounced and queued in a small FIFO with a valid/ready handshake toward a logger or soft CPU.

## Interface
- `DEBOUNCE_TICKS`, default 270000 (10 ms at 27 MHz): number of consecutive identical samples required to accept a press or a release.
- `FIFO_DEPTH`, default 4: output queue depth; must be a power of 2, at least 2.
- `clk` in, 1: system clock. Single clock domain.
- `reset` in, 1: synchronous, active-high reset.
- `key_0`..`key_7` in, 5 each: half-row vectors, active-low (0 = pressed). CS is `key_0[0]`; SS is `key_7[1]`.
- `code_out` out, 16: FIFO head; meaningful only while `code_valid` = 1.
- `code_valid` out, 1: FIFO non-empty.
- `code_ready` in, 1: consumer accepts the head when `code_valid` and `code_ready` are both 1 on a rising edge.
- `key_down` out, 1: 1 while in HELD or REL_DB.
- `overflow` out, 1: sticky; set when a push meets a full FIFO; cleared only by `reset`.

## Operation
- **Sampling.** All 40 input bits are registered into `m_q` every cycle. Modifier bits (`key_0[0]`, `key_7[1]`) are forced to 1 to form `m_nm`, the "non-modifier matrix".
- **Code format.**
  - [15:8]: row index 0..7 of the lowest-numbered row with any 0 in `m_nm`.
  - [7]: release marker (see Configuration); 0 otherwise.
  - [6]: CS pressed.
  - [5]: SS pressed.
  - [4:0]: that row's `m_nm` bits.
  - Other rows are ignored; there is no rollover.
- **FSM states:** IDLE, PRESS_DB, EMIT, HELD, REL_DB.
  - IDLE: if `m_nm` has any 0, snapshot `m_q`, clear the counter, and go to PRESS_DB. Modifier-only presses never leave IDLE.
  - PRESS_DB:
    - `m_q` equals the snapshot: the counter increments.
    - `m_q` differs and `m_nm` is all 1s: go to IDLE.
    - `m_q` differs otherwise: re-snapshot and clear the counter.
    - Counter reaches DEBOUNCE_TICKS: go to EMIT.
  - EMIT: build the code from the snapshot, push it, go to HELD. The push takes one cycle.
  - HELD: wait until `m_nm` is all 1s, then clear the counter and go to REL_DB. New keys and modifier changes are ignored.
  - REL_DB:
    - Any 0 in `m_nm`: return to HELD.
    - `m_nm` all 1s for DEBOUNCE_TICKS consecutive samples: go to IDLE.
- **FIFO.**
  - Pushing into a full FIFO drops the code and sets `overflow`.
  - Push and pop in the same cycle while full: the push is accepted and `overflow` is not set.
  - `code_out` is held stable while `code_valid` = 1 and `code_ready` = 0.
- **Counter.** 32-bit, saturating at DEBOUNCE_TICKS.

## Timing
- **Reset values.** After a `reset` cycle:
  - `code_out` = 0, `code_valid` = 0, `key_down` = 0, `overflow` = 0.
  - FIFO empty, FSM in IDLE, counter 0, `m_q` all 1s.
- **Reset mid-operation.** Reset in any state discards the snapshot and the queued codes. Nothing is emitted afterwards until a fresh press is debounced.
- **Press latency.** Inputs change at cycle 0 and then hold. The push happens at cycle DEBOUNCE_TICKS+2, and `code_valid` rises at cycle DEBOUNCE_TICKS+3. This latency is exact.
- **FIFO path.** No bypass: a push into an empty FIFO is visible the next cycle.
- **Pops.** One pop per cycle maximum; `code_valid` falls in the cycle after the last pop.
- **`key_down`.** Rises in the cycle after EMIT. Falls in the cycle after the REL_DB to IDLE transition.
- **Glitches.** A glitch shorter than DEBOUNCE_TICKS samples, in PRESS_DB or REL_DB, produces no code.

## Configuration
- **Macro:** `ZX_KEYDEC_RELEASE_EN`.
- **Defined:**
  - Leaving REL_DB for IDLE passes through an extra state, EMIT_REL.
  - EMIT_REL pushes the press code again with bit [7] = 1, then goes to IDLE one cycle later. Modifier bits are those captured at press.
  - `key_down` falls after EMIT_REL.
- **Undefined:**
  - Only press codes are emitted.
  - Bit [7] is always 0.
  - EMIT_REL logic is absent.

## Test plan
Bench settings: `DEBOUNCE_TICKS` = 4, `code_ready` = 1 unless stated.
- **Single key.** `key_1` = 11110 (A), held 20 cycles, then released → one code 0x011E. `code_valid` rises exactly 7 cycles after the input change. With the macro, 0x019E follows the release debounce.
- **Caps Shift.** `key_0` = 11110 and `key_2` = 11110 (CS+Q) → 0x025E. `key_0` = 11100 (CS+Z) → 0x005D. CS alone for 50 cycles → no code.
- **Symbol Shift.** `key_7` = 11101 and `key_5` = 11110 (SS+P) → 0x053E.
- **Bounce.** `key_3` = 11110 for 3 cycles, released for 2, then held → exactly one code 0x031E. `code_valid` rises 7 cycles after the final stable edge.
- **Overflow.** `code_ready` = 0; five distinct keys each pressed and released → 4 codes queued, then `overflow` = 1. Raising `code_ready` drains the first four codes in order, one per cycle.
- **Reset mid-operation.** `reset` pulsed during PRESS_DB and again during HELD → all outputs return to 0 the next cycle. No code appears for the interrupted key.
